// File: rtl/stream_accum_lanes_if.sv
// Stream handshake bundle for stream_accum_lanes: input beats (si_*) and output beats (so_*).
// The design uses the slave modport; the traffic source/sink uses master.
interface stream_accum_lanes_if #(
   parameter int DATA_W = 32
);
   logic              si_valid;
   logic              si_rdy;
   logic [DATA_W-1:0] si_data;
   logic              so_valid;
   logic              so_rdy;
   logic [DATA_W-1:0] so_data;

   modport master (
      output si_valid, si_data, so_rdy,
      input  si_rdy, so_valid, so_data
   );

   modport slave (
      input  si_valid, si_data, so_rdy,
      output si_rdy, so_valid, so_data
   );
endinterface

// File: rtl/stream_accum_lanes.sv
// Multi-lane stream accumulator: per-lane running prefix sums (or loopback) through one register
// stage and an output FIFO. Define STREAM_ACCUM_SAT_EN for saturating adds and a sticky sat_flag.
module stream_accum_lanes #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int CLR_BEATS  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   stream_accum_lanes_if.slave  bus,
   input  logic [1:0]           mode,
   input  logic                 acc_clr,
   output logic [31:0]          beat_cnt,
   output logic                 sat_flag
);

   localparam int LANES = DATA_W / 32;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_INC = (AW+1)'(1);

   typedef enum logic [1:0] {
      MODE_LOOP   = 2'b00,
      MODE_PREFIX = 2'b01,
      MODE_BEAT   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   // Returns {saturated, sum}; the wrap build never reports saturation.
   function automatic logic [32:0] lane_add(input logic [31:0] a, input logic [31:0] b);
`ifdef STREAM_ACCUM_SAT_EN
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? {1'b1, 32'hFFFF_FFFF} : {1'b0, s[31:0]};
`else
      return {1'b0, a + b};
`endif
   endfunction

   mode_e              mode_s;
   logic               si_rdy;
   logic               accept;
   logic               fifo_rd;
   logic               so_valid;
   logic [AW+1:0]      fill;

   logic [31:0]        acc_q, acc_d;
   logic [31:0]        clr_cnt_q, clr_cnt_d;
   logic [31:0]        beat_cnt_q;
   logic               p_valid_q;
   logic [DATA_W-1:0]  p_data_q;
   logic [AW:0]        wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0]  mem [FIFO_DEPTH];

   logic [31:0]        acc_base;
   logic [31:0]        run;
   logic [32:0]        add_r;
   logic               sat_any;
   logic [DATA_W-1:0]  sum_data;

   assign mode_s = mode_e'(mode);

   // Accepted-but-unread beats (FIFO plus pipe stage) bound acceptance, so the FIFO never overflows.
   assign fill     = {1'b0, wr_ptr_q - rd_ptr_q} + {{(AW+1){1'b0}}, p_valid_q};
   assign si_rdy   = !rst && (fill < (AW+2)'(FIFO_DEPTH));
   assign accept   = bus.si_valid && si_rdy;
   assign so_valid = (wr_ptr_q != rd_ptr_q);
   assign fifo_rd  = so_valid && bus.so_rdy;

   assign bus.si_rdy   = si_rdy;
   assign bus.so_valid = so_valid;
   assign bus.so_data  = so_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
   assign beat_cnt     = beat_cnt_q;

   // NOTE: every variable written here gets a default first, so no latch can be inferred.
   always_comb begin : adder_chain
      acc_base = acc_clr ? 32'd0 : acc_q;
      run      = (mode_s == MODE_BEAT) ? 32'd0 : acc_base;
      add_r    = '0;
      sat_any  = 1'b0;
      sum_data = '0;
      for (int i = 0; i < LANES; i++) begin
         add_r    = lane_add(run, bus.si_data[32*i +: 32]);
         run      = add_r[31:0];
         sat_any  = sat_any | add_r[32];
         sum_data[32*i +: 32] = run;
      end
   end

   // A clear lands before a coincident beat; the auto-clear lands after the CLR_BEATS-th beat.
   always_comb begin : acc_next
      clr_cnt_d = acc_clr ? 32'd0 : clr_cnt_q;
      acc_d     = acc_base;
      if (accept) begin
         clr_cnt_d = clr_cnt_d + 32'd1;
         if (mode_s != MODE_LOOP) begin
            acc_d = run;
         end
         if (CLR_BEATS != 0 && clr_cnt_d == 32'(CLR_BEATS)) begin
            acc_d     = 32'd0;
            clr_cnt_d = 32'd0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         clr_cnt_q  <= '0;
         beat_cnt_q <= '0;
         p_valid_q  <= 1'b0;
         p_data_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         acc_q     <= acc_d;
         clr_cnt_q <= clr_cnt_d;
         p_valid_q <= accept;
         if (accept) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            p_data_q   <= (mode_s == MODE_LOOP) ? bus.si_data : sum_data;
         end
         if (p_valid_q) begin
            wr_ptr_q <= wr_ptr_q + PTR_INC;
         end
         if (fifo_rd) begin
            rd_ptr_q <= rd_ptr_q + PTR_INC;
         end
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (p_valid_q) begin
         mem[wr_ptr_q[AW-1:0]] <= p_data_q;
      end
   end

`ifdef STREAM_ACCUM_SAT_EN
   logic sat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= (acc_clr ? 1'b0 : sat_q) | (accept && mode_s != MODE_LOOP && sat_any);
      end
   end

   assign sat_flag = sat_q;
`else
   wire unused_sat = sat_any;

   assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_stream_accum_lanes.sv
// Self-checking bench for stream_accum_lanes: directed literal cases plus randomized traffic,
// all checked against a lane-arithmetic reference model; honours STREAM_ACCUM_SAT_EN.
module tb_stream_accum_lanes;

   localparam int DATA_W     = 128;
   localparam int LANES      = DATA_W / 32;
   localparam int FIFO_DEPTH = 4;
   localparam int CLR_BEATS  = 3;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic        acc_clr;
   logic [31:0] beat_cnt;
   logic        sat_flag;

   stream_accum_lanes_if #(.DATA_W(DATA_W)) bus ();

   stream_accum_lanes #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CLR_BEATS(CLR_BEATS)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .mode(mode), .acc_clr(acc_clr),
      .beat_cnt(beat_cnt), .sat_flag(sat_flag)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] obs[$];
   logic [31:0]       m_acc;
   int                m_cnt;
   logic [31:0]       m_beats;
   logic              m_sat;

   // so_rdy driver control: 0 hold rdy_hold, 1 toggle, 2 random
   int   rdy_mode = 0;
   logic rdy_hold = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      bus.so_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       bus.so_rdy = rdy_hold;
            1:       bus.so_rdy = ~bus.so_rdy;
            default: bus.so_rdy = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] pack(input logic [31:0] l3, input logic [31:0] l2,
                                               input logic [31:0] l1, input logic [31:0] l0);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [DATA_W-1:0] splat(input logic [31:0] x);
      return {x, x, x, x};
   endfunction

   function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] s;
      s = {32'd0, a} + {32'd0, b};
`ifdef STREAM_ACCUM_SAT_EN
      if (s > 64'h0000_0000_FFFF_FFFF) begin
         m_sat = 1'b1;
         return 32'hFFFF_FFFF;
      end
`endif
      return s[31:0];
   endfunction

   // Output beat for one accepted input beat: lane i = base + sum of lanes 0..i.
   function automatic logic [DATA_W-1:0] model_beat(input logic [DATA_W-1:0] d, input logic [1:0] md);
      logic [31:0]       run;
      logic [DATA_W-1:0] r;
      if (md == 2'b00) return d;
      run = (md == 2'b10) ? 32'd0 : m_acc;
      r   = '0;
      for (int i = 0; i < LANES; i++) begin
         run = m_add(run, d[32*i +: 32]);
         r[32*i +: 32] = run;
      end
      m_acc = run;
      return r;
   endfunction

   // Compare process: everything seen at a negedge is what the next posedge will act on.
   logic              stall_prev = 1'b0;
   logic [DATA_W-1:0] data_prev  = '0;

   always @(negedge clk) begin
      if (rst) begin
         check("si_rdy_in_reset", bus.si_rdy, 0);
         exp_q.delete();
         m_acc = 32'd0; m_cnt = 0; m_beats = 32'd0; m_sat = 1'b0;
         stall_prev = 1'b0;
      end else begin
         check("si_rdy", bus.si_rdy, (exp_q.size() < FIFO_DEPTH));
         check("beat_cnt", beat_cnt, m_beats);
         check("sat_flag", sat_flag, m_sat);
         if (stall_prev) begin
            check("hold_valid", bus.so_valid, 1);
            check("hold_data", bus.so_data, data_prev);
         end
         if (bus.so_valid && bus.so_rdy) begin
            obs.push_back(bus.so_data);
            if (exp_q.size() == 0) check("spurious_output", bus.so_data, 'x);
            else check("out_data", bus.so_data, exp_q.pop_front());
         end
         if (acc_clr) begin
            m_acc = 32'd0; m_cnt = 0; m_sat = 1'b0;
         end
         if (bus.si_valid && bus.si_rdy) begin
            exp_q.push_back(model_beat(bus.si_data, mode));
            m_beats = m_beats + 32'd1;
            m_cnt++;
            if (CLR_BEATS != 0 && m_cnt == CLR_BEATS) begin
               m_acc = 32'd0; m_cnt = 0;
            end
         end
         stall_prev = bus.so_valid && !bus.so_rdy;
         data_prev  = bus.so_data;
      end
   end

   // Present one beat until accepted; returns just after the accepting edge.
   task automatic send(input logic [DATA_W-1:0] d, input logic [1:0] md, input logic clr);
      int t = 0;
      bit done = 1'b0;
      bus.si_valid = 1'b1; bus.si_data = d; mode = md; acc_clr = clr;
      while (!done && t < 300) begin
         @(negedge clk);
         done = bus.si_rdy;
         @(posedge clk);
         #1;
         t++;
      end
      bus.si_valid = 1'b0; acc_clr = 1'b0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic wait_obs(input int target);
      int t = 0;
      while (obs.size() < target && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("obs_count", obs.size(), target);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_obs(input string name, input int idx, input logic [DATA_W-1:0] exp);
      check(name, (idx < obs.size()) ? obs[idx] : 'x, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int k;
      int t;
      logic [DATA_W-1:0] sat_exp;
      logic              sat_flag_exp;

      bus.si_valid = 1'b0; bus.si_data = '0; mode = 2'b01; acc_clr = 1'b0; rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_so_valid", bus.so_valid, 0);
      check("rst_so_data", bus.so_data, 0);
      check("rst_beat_cnt", beat_cnt, 0);
      check("rst_sat_flag", sat_flag, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("si_rdy_after_rst", bus.si_rdy, 1);
      @(posedge clk);
      #1;

      // Lane order
      base = obs.size();
      send(pack(3, 2, 1, 0), 2'b01, 1'b1);
      send(pack(7, 6, 5, 4), 2'b01, 1'b0);
      wait_obs(base + 2);
      expect_obs("lane_order_0", base, pack(6, 3, 1, 0));
      expect_obs("lane_order_1", base + 1, pack(28, 21, 15, 10));

      // Clear coincident with a beat after acc = 100
      base = obs.size();
      send(pack(0, 0, 0, 100), 2'b01, 1'b1);
      send(pack(0, 0, 0, 5), 2'b01, 1'b1);
      wait_obs(base + 2);
      expect_obs("acc_100", base, splat(100));
      expect_obs("clr_coincident", base + 1, splat(5));

      // Auto-clear after CLR_BEATS = 3 beats
      base = obs.size();
      send(pack(0, 0, 0, 1), 2'b01, 1'b1);
      repeat (3) send(pack(0, 0, 0, 1), 2'b01, 1'b0);
      wait_obs(base + 4);
      expect_obs("auto_clr_0", base, splat(1));
      expect_obs("auto_clr_1", base + 1, splat(2));
      expect_obs("auto_clr_2", base + 2, splat(3));
      expect_obs("auto_clr_3", base + 3, splat(1));

      // Loopback leaves acc untouched
      base = obs.size();
      send(pack(0, 0, 0, 10), 2'b01, 1'b1);
      send(splat(32'hDEAD_BEEF), 2'b00, 1'b0);
      send(pack(0, 0, 0, 1), 2'b01, 1'b0);
      wait_obs(base + 3);
      expect_obs("loopback", base + 1, splat(32'hDEAD_BEEF));
      expect_obs("acc_kept", base + 2, splat(11));

      // Per-beat sum and two-cycle latency from an empty FIFO
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1;
      base = obs.size();
      send(pack(0, 0, 0, 4), 2'b10, 1'b0);
      @(negedge clk);
      check("lat_n1_so_valid", bus.so_valid, 0);
      @(negedge clk);
      check("lat_n2_so_valid", bus.so_valid, 1);
      check("lat_n2_so_data", bus.so_data, splat(4));
      @(posedge clk);
      #1;
      send(pack(0, 0, 0, 4), 2'b10, 1'b0);
      wait_obs(base + 2);
      expect_obs("per_beat_1", base + 1, splat(4));

      // Saturation versus wrap
`ifdef STREAM_ACCUM_SAT_EN
      sat_exp = splat(32'hFFFF_FFFF); sat_flag_exp = 1'b1;
`else
      sat_exp = splat(32'h0000_0010); sat_flag_exp = 1'b0;
`endif
      base = obs.size();
      send(pack(0, 0, 0, 32'hFFFF_FFF0), 2'b01, 1'b1);
      send(pack(0, 0, 0, 32'h20), 2'b01, 1'b0);
      @(negedge clk);
      check("sat_flag_literal", sat_flag, sat_flag_exp);
      @(posedge clk);
      #1;
      wait_obs(base + 2);
      expect_obs("sat_data", base + 1, sat_exp);

      // Backpressure: FIFO of 4, so_rdy low, 10 beats offered
      rdy_mode = 0; rdy_hold = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      base = obs.size();
      k = 0; mode = 2'b00; acc_clr = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bus.si_valid = 1'b1; bus.si_data = splat(k + 1);
         @(negedge clk);
         if (bus.si_rdy) k++;
         @(posedge clk);
         #1;
      end
      check("bp_accepted", k, 4);
      check("bp_si_rdy_low", bus.si_rdy, 0);
      rdy_mode = 1;
      t = 0;
      while (k < 10 && t < 200) begin
         bus.si_valid = 1'b1; bus.si_data = splat(k + 1);
         @(negedge clk);
         if (bus.si_rdy) k++;
         @(posedge clk);
         #1;
         t++;
      end
      bus.si_valid = 1'b0;
      rdy_mode = 0; rdy_hold = 1'b1;
      wait_obs(base + 10);
      repeat (5) @(negedge clk);
      check("bp_no_dup", obs.size() - base, 10);
      check("bp_beat_cnt", beat_cnt, 10);
      for (int i = 0; i < 10; i++) expect_obs("bp_order", base + i, splat(i + 1));
      @(posedge clk);
      #1;

      // Reset with three beats buffered
      rdy_hold = 1'b0;
      @(posedge clk);
      #1;
      send(pack(0, 0, 0, 1), 2'b01, 1'b1);
      send(pack(0, 0, 0, 2), 2'b01, 1'b0);
      send(pack(0, 0, 0, 3), 2'b01, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      base = obs.size();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; rdy_hold = 1'b1;
      @(negedge clk);
      check("mid_rst_so_valid", bus.so_valid, 0);
      check("mid_rst_beat_cnt", beat_cnt, 0);
      @(posedge clk);
      #1;
      send(pack(0, 0, 0, 9), 2'b01, 1'b0);
      wait_obs(base + 1);
      repeat (4) @(negedge clk);
      check("mid_rst_discard", obs.size() - base, 1);
      expect_obs("mid_rst_next", base, splat(9));
      @(posedge clk);
      #1;

      // Randomized traffic against the model
      rdy_mode = 2;
      for (int i = 0; i < 1500; i++) begin
         bus.si_valid = ($urandom_range(0, 3) != 0);
         bus.si_data  = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 1) == 0) bus.si_data = bus.si_data & {LANES{32'h0000_FFFF}};
         mode    = 2'($urandom_range(0, 3));
         acc_clr = ($urandom_range(0, 15) == 0);
         @(posedge clk);
         #1;
      end
      bus.si_valid = 1'b0; acc_clr = 1'b0;
      rdy_mode = 0; rdy_hold = 1'b1;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_accum_lanes.md
# stream_accum_lanes

Parametrised stream accumulator for the 32-bit Pico stream loopback path: each accepted input beat carries `DATA_W/32` 32-bit lanes, and the block returns their running prefix sums, or a plain loopback, on the paired output stream. It sits between the host-to-card stream endpoint and the card-to-host stream endpoint of one stream ID. It replaces the fixed 32-bit, single-lane accumulator with configurable width, an output buffer, modes, clear control and beat accounting.

## Interface
- `DATA_W`, 32: stream width; must be a multiple of 32; `LANES = DATA_W/32`.
- `FIFO_DEPTH`, 16: output buffer entries, a power of two, ≥4.
- `CLR_BEATS`, 0: auto-clear the accumulator after this many accepted beats; 0 disables auto-clear.
- Reset is synchronous and active-high on `rst`; single clock `clk`.
- `clk`  in  1  stream clock.
- `rst`  in  1  synchronous active-high reset.
- `si_valid`  in  1  input beat valid.
- `si_rdy`  out  1  block can accept an input beat.
- `si_data`  in  DATA_W  input beat; lane i is bits [32i+31:32i]; lane 0 is oldest.
- `so_valid`  out  1  output beat valid.
- `so_rdy`  in  1  downstream accepts the output beat.
- `so_data`  out  DATA_W  output beat, with the same lane order as the input.
- `mode`  in  2  00 loopback, 01 prefix sum, 10 per-beat sum (accumulator reset every beat), 11 reserved (behaves as 01).
- `acc_clr`  in  1  one-cycle accumulator clear request.
- `beat_cnt`  out  32  count of accepted input beats; wraps at 2^32.
- `sat_flag`  out  1  sticky flag, set when saturation occurred (only with the macro defined).

## Operation
- Accept: an input beat transfers when `si_valid & si_rdy`.
- `si_rdy` = (FIFO occupancy + pipe-stage valid) < `FIFO_DEPTH`.
- Sum: for lane i, `out_i = acc + Σ in_0..in_i`, mod 2^32 (wrap) per lane.
  - After the beat, `acc ← out_{LANES-1}`.
  - Mode 10 uses acc = 0 for every beat.
  - Mode 00 passes the beat through unchanged and leaves acc untouched.
- Clear: `acc_clr`, or reaching `CLR_BEATS` accepted beats since the last clear, sets acc to 0.
  - A clear in the same cycle as an accepted beat takes effect before that beat, so the beat sums from 0.
  - The auto-clear fires after the CLR_BEATS-th beat: beat CLR_BEATS+1 starts from 0.
- Mode changes: `mode` is sampled per accepted beat. Changing it mid-stream does not flush the buffer or clear acc.
- Pipeline: one register stage (adder chain → `p_data`, `p_valid`), then an output FIFO of depth `FIFO_DEPTH`.
  - The FIFO is written when `p_valid`.
  - The FIFO is never full on write; `si_rdy` guarantees this.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguished; addresses wrap naturally.
- A simultaneous FIFO write and read keeps the occupancy unchanged, including at full-1 and at empty. Write-through from empty is not allowed: the data is still registered.
- Reset mid-operation: in-flight beats are discarded.
- Reset values:
  - `si_rdy` = 0 during `rst`, 1 on the first cycle after.
  - `so_valid` = 0.
  - `so_data` = 0.
  - `beat_cnt` = 0.
  - `sat_flag` = 0.
  - acc = 0, FIFO empty.

## Timing
- Latency from acceptance at edge N (FIFO empty, `so_rdy` high): `p_valid` at N+1, `so_valid` with the data at N+2.
- Throughput is one beat per cycle, sustained with `so_rdy` held high.
- `so_data` and `so_valid` are held stable while `so_valid & !so_rdy`.
- `beat_cnt` updates the cycle after acceptance.
- The adder chain is combinational across LANES within one stage. With `DATA_W` > 256 the chain is timing-critical; the block is qualified to 256.

## Configuration
- `STREAM_ACCUM_SAT_EN`:
  - Defined: lane and acc additions saturate at 0xFFFFFFFF instead of wrapping, and `sat_flag` sets sticky until `rst` or `acc_clr`.
  - Undefined: additions wrap mod 2^32 and `sat_flag` is tied to 0.

## Test plan
- Baseline: DATA_W=32, mode 01, words 0..3071 sent as three 1024-word bursts, `so_rdy` high -> output word n = n(n+1)/2; last word = 4717056 (0x0047FA00).
- Lane order: DATA_W=128, mode 01, beats {3,2,1,0} then {7,6,5,4} (lane 0 rightmost) -> outputs {6,3,1,0} then {28,21,15,10}.
- Backpressure: FIFO_DEPTH=4, `so_rdy` low, 10 beats offered -> exactly 4 accepted and `si_rdy` drops. Then `so_rdy` toggling 1/0 -> all 10 outputs in order, no loss or duplication, `beat_cnt` = 10.
- Clear and modes:
  - `acc_clr` coincident with input 5 after acc = 100 -> output 5.
  - CLR_BEATS=2, inputs 1,1,1 -> outputs 1,2,1.
  - Mode 00, input 0xDEADBEEF -> output 0xDEADBEEF, acc unchanged.
  - Mode 10, inputs 4,4 -> 4,4.
- Saturation: acc = 0xFFFFFFF0, input 0x20 -> 0xFFFFFFFF with `sat_flag`=1 when `STREAM_ACCUM_SAT_EN` is defined; 0x00000010 with `sat_flag`=0 when it is undefined.
- Reset mid-stream: assert `rst` for one cycle with 3 beats buffered -> `so_valid` 0 on the next cycle, `beat_cnt` 0; next input 9 -> output 9.
